// File: rtl/jtkiwi_gfx_fetch.sv
// Graphics ROM fetch arbiter: serves the tile (scr) and sprite (obj) 32-bit
// read ports from one shared SDRAM read channel. Each client has a one-entry
// cache, so a repeated address needs no SDRAM access. When both clients miss
// at once, a round-robin pointer decides who goes first.
//
// SDRAM handshake: sdram_req is raised with a stable sdram_addr and held until
// the one-cycle sdram_ack pulse; after that the address may change. One
// sdram_rdy pulse later delivers sdram_dout for the accepted request. An ack
// outside REQ and a rdy outside WAIT are ignored.
module jtkiwi_gfx_fetch #(
  parameter logic [21:0] SCR_OFFSET = 22'h00000,
  parameter logic [21:0] OBJ_OFFSET = 22'h80000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scr_cs,
  input  logic [17:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // FSM state is kept under a plain name so checkers can bind to it.
  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [21:0] saddr_q, saddr_d;
  logic        client_q, client_d;   // 0: scr, 1: obj
  logic [17:0] addr_q, addr_d;       // latched client address, becomes the tag
  logic        rr_q, rr_d;           // 0: scr wins next double miss, 1: obj

  logic        scr_valid_q, scr_valid_d;
  logic [17:0] scr_tag_q, scr_tag_d;
  logic [31:0] scr_data_q, scr_data_d;
  logic        obj_valid_q, obj_valid_d;
  logic [17:0] obj_tag_q, obj_tag_d;
  logic [31:0] obj_data_q, obj_data_d;

  logic        scr_miss, obj_miss;
  logic        grant_obj;
  logic [17:0] sel_addr;
  logic [21:0] sel_offset;
  logic [21:0] sel_sdram;

  // Hits are purely combinational from the cache registers.
  assign scr_ok     = scr_cs & scr_valid_q & (scr_tag_q == scr_addr);
  assign obj_ok     = obj_cs & obj_valid_q & (obj_tag_q == obj_addr);
  assign scr_miss   = scr_cs & ~scr_ok;
  assign obj_miss   = obj_cs & ~obj_ok;
  assign scr_data   = scr_data_q;
  assign obj_data   = obj_data_q;
  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;

  // Grant selection: a lone miss wins, a double miss follows the rr pointer.
  always_comb begin
    grant_obj  = obj_miss & (~scr_miss | rr_q);
    sel_addr   = grant_obj ? obj_addr : scr_addr;
    sel_offset = grant_obj ? OBJ_OFFSET : SCR_OFFSET;
    // 16-bit word address; the add wraps at 22 bits on purpose.
    sel_sdram  = {3'b000, sel_addr, 1'b0} + sel_offset;
  end

  // Next-state logic: arbitration, SDRAM handshake and cache fill.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    saddr_d     = saddr_q;
    client_d    = client_q;
    addr_d      = addr_q;
    rr_d        = rr_q;
    scr_valid_d = scr_valid_q;
    scr_tag_d   = scr_tag_q;
    scr_data_d  = scr_data_q;
    obj_valid_d = obj_valid_q;
    obj_tag_d   = obj_tag_q;
    obj_data_d  = obj_data_q;
    case (state_q)
      ST_IDLE: begin
        if (scr_miss | obj_miss) begin
          client_d = grant_obj;
          addr_d   = sel_addr;
          saddr_d  = sel_sdram;
          req_d    = 1'b1;
          state_d  = ST_REQ;
          if (scr_miss & obj_miss) rr_d = ~rr_q;
        end
      end
      ST_REQ: begin
        // A rdy arriving together with ack is a controller error: ignored.
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The fill uses the latched address even if the client moved on.
        if (sdram_rdy) begin
          if (client_q) begin
            obj_valid_d = 1'b1;
            obj_tag_d   = addr_q;
            obj_data_d  = sdram_dout;
          end else begin
            scr_valid_d = 1'b1;
            scr_tag_d   = addr_q;
            scr_data_d  = sdram_dout;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and cache registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      saddr_q     <= 22'd0;
      client_q    <= 1'b0;
      addr_q      <= 18'd0;
      rr_q        <= 1'b0;
      scr_valid_q <= 1'b0;
      scr_tag_q   <= 18'd0;
      scr_data_q  <= 32'd0;
      obj_valid_q <= 1'b0;
      obj_tag_q   <= 18'd0;
      obj_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      saddr_q     <= saddr_d;
      client_q    <= client_d;
      addr_q      <= addr_d;
      rr_q        <= rr_d;
      scr_valid_q <= scr_valid_d;
      scr_tag_q   <= scr_tag_d;
      scr_data_q  <= scr_data_d;
      obj_valid_q <= obj_valid_d;
      obj_tag_q   <= obj_tag_d;
      obj_data_q  <= obj_data_d;
    end
  end

endmodule

// File: tb/tb_jtkiwi_gfx_fetch.sv
// Bench for jtkiwi_gfx_fetch: table of single-client misses, then hand-written
// sequences for round-robin, mid-transaction address change, reset during a
// request and 22-bit address wrap (second instance with a large OBJ_OFFSET).
module tb_jtkiwi_gfx_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        scr_cs = 0, obj_cs = 0;
  logic [17:0] scr_addr = 0, obj_addr = 0;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 0, sdram_rdy = 0;
  logic [31:0] sdram_dout = 0;

  jtkiwi_gfx_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout)
  );

  // Second instance for the 22-bit wrap of the offset add.
  logic        w_obj_cs = 0;
  logic [17:0] w_obj_addr = 0;
  logic [31:0] w_scr_data, w_obj_data;
  logic        w_scr_ok, w_obj_ok;
  logic [21:0] w_sdram_addr;
  logic        w_sdram_req;

  jtkiwi_gfx_fetch #(.OBJ_OFFSET(22'h3FFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .scr_cs(1'b0), .scr_addr(18'd0), .scr_data(w_scr_data), .scr_ok(w_scr_ok),
    .obj_cs(w_obj_cs), .obj_addr(w_obj_addr), .obj_data(w_obj_data), .obj_ok(w_obj_ok),
    .sdram_addr(w_sdram_addr), .sdram_req(w_sdram_req), .sdram_ack(1'b0),
    .sdram_rdy(1'b0), .sdram_dout(32'd0)
  );

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic cur_ok(input bit cl);
    return cl ? obj_ok : scr_ok;
  endfunction

  function automatic logic [31:0] cur_data(input bit cl);
    return cl ? obj_data : scr_data;
  endfunction

  // ---------------- SDRAM driver ----------------
  // Waits for a request, checks its address against the scoreboard, acks
  // after aw extra REQ cycles, returns data after rw extra WAIT cycles and
  // checks the granted client's cache output the cycle after rdy.
  task automatic serve(input bit cl, input logic [31:0] d, input int aw,
                       input int rw, input string nm);
    int n;
    logic [21:0] e;
    n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s req_seen", nm), {31'd0, sdram_req}, 32'd1);
    if (!sdram_req) return;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: request with empty expected queue, addr %h", nm, sdram_addr);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("%s sdram_addr", nm), {10'd0, sdram_addr}, {10'd0, e});
    for (int i = 0; i < aw; i++) begin
      @(negedge clk);
      chk($sformatf("%s req_held", nm), {31'd0, sdram_req}, 32'd1);
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    chk($sformatf("%s req_drop", nm), {31'd0, sdram_req}, 32'd0);
    chk($sformatf("%s ok_in_wait", nm), {31'd0, cur_ok(cl)}, 32'd0);
    repeat (rw) @(negedge clk);
    sdram_dout = d;
    sdram_rdy  = 1'b1;
    @(negedge clk);
    sdram_rdy  = 1'b0;
    chk($sformatf("%s ok_after", nm), {31'd0, cur_ok(cl)}, 32'd1);
    chk($sformatf("%s data", nm), cur_data(cl), d);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          cl;
    logic [17:0] addr;
    logic [31:0] d;
    int          aw;
    int          rw;
    logic [21:0] exp_sa;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] exp_scr_d, exp_obj_d;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    vecs[0] = '{0, 18'h00010, 32'hDEADBEEF, 0, 0, 22'h00020};
    vecs[1] = '{1, 18'h00100, 32'h12345678, 2, 3, 22'h80200};
    vecs[2] = '{0, 18'h3FFFF, 32'hA5A5C3C3, 1, 0, 22'h07FFFE};
    vecs[3] = '{1, 18'h3FFFF, 32'h0F0F1234, 0, 2, 22'h0FFFFE};
    vecs[4] = '{0, 18'h20000, 32'h55AA00FF, 3, 1, 22'h040000};
    exp_scr_d = 32'd0;
    exp_obj_d = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst sdram_req", {31'd0, sdram_req}, 32'd0);
    chk("rst sdram_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst scr_data", scr_data, 32'd0);
    chk("rst obj_data", obj_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    scr_cs = 1'b1;
    obj_cs = 1'b1;
    #1;
    chk("rst scr_ok", {31'd0, scr_ok}, 32'd0);
    chk("rst obj_ok", {31'd0, obj_ok}, 32'd0);
    scr_cs = 1'b0;
    obj_cs = 1'b0;

    // Single-client misses, then hits on the same address.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      if (vecs[v].cl) begin obj_cs = 1'b1; obj_addr = vecs[v].addr; end
      else            begin scr_cs = 1'b1; scr_addr = vecs[v].addr; end
      exp_q.push_back(vecs[v].exp_sa);
      serve(vecs[v].cl, vecs[v].d, vecs[v].aw, vecs[v].rw, $sformatf("vec%0d", v));
      if (vecs[v].cl) exp_obj_d = vecs[v].d; else exp_scr_d = vecs[v].d;
      chk($sformatf("vec%0d scr_data_kept", v), scr_data, exp_scr_d);
      chk($sformatf("vec%0d obj_data_kept", v), obj_data, exp_obj_d);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("vec%0d hit_no_req", v), {31'd0, sdram_req}, 32'd0);
        chk($sformatf("vec%0d hit_ok", v), {31'd0, cur_ok(vecs[v].cl)}, 32'd1);
      end
      scr_cs = 1'b0;
      obj_cs = 1'b0;
      #1;
      chk($sformatf("vec%0d ok_needs_cs", v), {31'd0, cur_ok(vecs[v].cl)}, 32'd0);
    end

    // Double miss: scr first (pointer at scr), then obj; next double miss obj first.
    @(negedge clk);
    scr_cs = 1'b1; scr_addr = 18'h00001;
    obj_cs = 1'b1; obj_addr = 18'h00002;
    exp_q.push_back(22'h000002);
    exp_q.push_back(22'h080004);
    serve(0, 32'h11110001, 0, 0, "rr1 scr");
    serve(1, 32'h22220002, 0, 0, "rr1 obj");
    chk("rr1 scr_still_ok", {31'd0, scr_ok}, 32'd1);
    scr_addr = 18'h00005;
    obj_addr = 18'h00006;
    exp_q.push_back(22'h08000C);
    exp_q.push_back(22'h00000A);
    serve(1, 32'h33330006, 1, 0, "rr2 obj");
    serve(0, 32'h44440005, 0, 1, "rr2 scr");
    chk("rr2 obj_still_ok", {31'd0, obj_ok}, 32'd1);
    obj_cs = 1'b0;

    // scr address changes while the fill is outstanding.
    @(negedge clk);
    scr_addr = 18'h00010;
    exp_q.push_back(22'h000020);
    begin : addr_change
      int n;
      n = 0;
      while (!sdram_req && n < 20) begin @(negedge clk); n++; end
      chk("chg req_seen", {31'd0, sdram_req}, 32'd1);
      chk("chg sdram_addr", {10'd0, sdram_addr}, {10'd0, exp_q.pop_front()});
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      scr_addr  = 18'h00011;
      sdram_dout = 32'hCAFE0010;
      sdram_rdy  = 1'b1;
      @(negedge clk);
      sdram_rdy  = 1'b0;
      chk("chg ok_stays_low", {31'd0, scr_ok}, 32'd0);
      chk("chg data_old_addr", scr_data, 32'hCAFE0010);
    end
    exp_q.push_back(22'h000022);
    serve(0, 32'hCAFE0011, 0, 0, "chg refetch");
    scr_cs = 1'b0;

    // Reset during REQ, then stray rdy/ack with nothing pending.
    @(negedge clk);
    obj_cs = 1'b1; obj_addr = 18'h00007;
    begin : reset_mid
      int n;
      n = 0;
      while (!sdram_req && n < 20) begin @(negedge clk); n++; end
      chk("rstmid req_seen", {31'd0, sdram_req}, 32'd1);
      rst_n  = 1'b0;
      obj_cs = 1'b0;
      #1;
      chk("rstmid req_drop", {31'd0, sdram_req}, 32'd0);
      chk("rstmid sdram_addr", {10'd0, sdram_addr}, 32'd0);
      chk("rstmid obj_data", obj_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sdram_dout = 32'hBAD0BAD0;
      sdram_rdy  = 1'b1;
      sdram_ack  = 1'b1;
      @(negedge clk);
      sdram_rdy = 1'b0;
      sdram_ack = 1'b0;
      @(negedge clk);
      chk("rstmid no_req", {31'd0, sdram_req}, 32'd0);
      chk("rstmid obj_data_clear", obj_data, 32'd0);
      obj_cs = 1'b1; obj_addr = 18'h00007;
      scr_cs = 1'b1; scr_addr = 18'h00010;
      #1;
      chk("rstmid obj_ok", {31'd0, obj_ok}, 32'd0);
      chk("rstmid scr_ok", {31'd0, scr_ok}, 32'd0);
      obj_cs = 1'b0;
      scr_cs = 1'b0;
    end

    // Offset add wraps at 22 bits.
    @(negedge clk);
    w_obj_cs = 1'b1;
    w_obj_addr = 18'h3FFFF;
    @(negedge clk);
    chk("wrap req", {31'd0, w_sdram_req}, 32'd1);
    chk("wrap sdram_addr", {10'd0, w_sdram_addr}, {10'd0, 22'h07FFFD});

    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
